// File: rtl/control_multicycle_pkg.sv
// Shared constants for the multi-cycle control unit: FSM state codes,
// RV32I opcodes, ALU operation codes and immediate-format selectors.
package control_pkg;

    // Main FSM state codes (plain constants so legacy tools can dump them).
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;

    // Opcodes (instr[6:0]) understood by the control unit.
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;

    // What the FSM asks of the ALU decoder in a given state.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Full 4-bit ALU encoding. The 3-bit legacy encoding is the low three
    // bits of add/sub/and/or/slt, so truncation yields the legacy code.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Immediate format selectors for the datapath extender.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format is a pure function of the opcode.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/control_multicycle_if.sv
// Bundle between the instruction register / ALU flags / memory and the
// control unit. slave = control unit side, master = datapath side.
interface control_multicycle_if #(
    parameter int ALUCTRL_W = 4
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 Lt;
    logic                 Ltu;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [2:0]           ImmSrc;
    logic                 RegWrite;
    logic                 illegal;

    modport slave (
        input  op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal
    );

    modport master (
        output op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal
    );
endinterface

// File: rtl/control_multicycle_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU request plus funct fields
// to an ALUControl code, and flags funct combinations this build rejects.
module alu_decoder
    import control_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  aluop_e               alu_op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal_funct
);

    // Legacy builds only implement add/sub/and/or/slt.
    localparam bit LEGACY = (ALUCTRL_W == 3);

    logic       r_alt;
    logic [3:0] funct_code;
    logic [3:0] code_sel;

    // funct7b5 is an opcode modifier only for R-type; for I-type it is an
    // immediate bit, except on the shifts where it selects srai / rejects slli.
    assign r_alt = op5 & funct7b5;

    // Decode funct3/funct7b5 independently of the FSM so DECODE can check legality.
    always_comb begin
        funct_code    = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct3)
            3'b000: funct_code = r_alt ? ALU_SUB : ALU_ADD;
            3'b001: begin
                funct_code    = ALU_SLL;
                illegal_funct = LEGACY | funct7b5;
            end
            3'b010: begin
                funct_code    = ALU_SLT;
                illegal_funct = r_alt;
            end
            3'b011: begin
                funct_code    = ALU_SLTU;
                illegal_funct = LEGACY | r_alt;
            end
            3'b100: begin
                funct_code    = ALU_XOR;
                illegal_funct = LEGACY | r_alt;
            end
            3'b101: begin
                funct_code    = funct7b5 ? ALU_SRA : ALU_SRL;
                illegal_funct = LEGACY;
            end
            3'b110: begin
                funct_code    = ALU_OR;
                illegal_funct = r_alt;
            end
            default: begin
                funct_code    = ALU_AND;
                illegal_funct = r_alt;
            end
        endcase
        if (illegal_funct) begin
            funct_code = ALU_ADD;
        end
    end

    // Select between the FSM's fixed add/sub requests and the funct decode.
    always_comb begin
        case (alu_op)
            ALUOP_ADD: code_sel = ALU_ADD;
            ALUOP_SUB: code_sel = ALU_SUB;
            default:   code_sel = funct_code;
        endcase
    end

    assign alu_control = code_sel[ALUCTRL_W-1:0];

endmodule

// File: rtl/control_multicycle.sv
// Multi-cycle RV32I control unit: registered main FSM sequencing
// fetch/decode/execute/memory/writeback over a shared memory and ALU,
// with memory wait states, branch resolution and illegal-op detection.
module control_multicycle
    import control_pkg::*;
#(
    parameter int ALUCTRL_W  = 4,
    parameter bit EXT_BRANCH = 1'b1,
    parameter bit MEM_WAIT   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    control_multicycle_if.slave  bus
);

    logic [3:0]           state_q;
    logic [3:0]           state_d;
    logic                 ready_eff;
    aluop_e               alu_op;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 illegal_funct;
    logic                 branch_legal;
    logic                 branch_taken;
    logic [3:0]           decode_next;
    logic                 decode_illegal;

    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic [1:0]           result_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic                 reg_write;
    logic                 illegal_pulse;

    // Without wait states every access is assumed to complete in one cycle.
    assign ready_eff = MEM_WAIT ? bus.mem_ready : 1'b1;

    alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .alu_op        (alu_op),
        .funct3        (bus.funct3),
        .funct7b5      (bus.funct7b5),
        .op5           (bus.op[5]),
        .alu_control   (alu_ctrl),
        .illegal_funct (illegal_funct)
    );

    // Branch condition: legality of funct3 and taken/not-taken from the flags.
    always_comb begin
        branch_legal = 1'b1;
        branch_taken = 1'b0;
        case (bus.funct3)
            3'b000: branch_taken = bus.Zero;
            3'b001: branch_taken = ~bus.Zero;
            3'b100: branch_taken = bus.Lt;
            3'b101: branch_taken = ~bus.Lt;
            3'b110: branch_taken = bus.Ltu;
            3'b111: branch_taken = ~bus.Ltu;
            default: branch_legal = 1'b0;
        endcase
        if (!EXT_BRANCH && bus.funct3 != 3'b000) begin
            branch_legal = 1'b0;
        end
        if (!branch_legal) begin
            branch_taken = 1'b0;
        end
    end

    // Opcode dispatch out of DECODE; unsupported encodings return to FETCH.
    always_comb begin
        decode_next    = S_FETCH;
        decode_illegal = 1'b0;
        case (bus.op)
            OP_LOAD, OP_STORE: decode_next = S_MEMADR;
            OP_RTYPE: begin
                decode_next    = illegal_funct ? S_FETCH : S_EXECR;
                decode_illegal = illegal_funct;
            end
            OP_ITYPE: begin
                decode_next    = illegal_funct ? S_FETCH : S_EXECI;
                decode_illegal = illegal_funct;
            end
            OP_BRANCH: begin
                decode_next    = branch_legal ? S_BRANCH : S_FETCH;
                decode_illegal = ~branch_legal;
            end
            OP_JAL:  decode_next = S_JAL;
            OP_LUI:  decode_next = S_LUI;
            default: decode_illegal = 1'b1;
        endcase
    end

    // ALU request depends on state only, keeping it clear of the decode path.
    always_comb begin
        case (state_q)
            S_EXECR, S_EXECI: alu_op = ALUOP_FUNCT;
            S_BRANCH:         alu_op = ALUOP_SUB;
            default:          alu_op = ALUOP_ADD;
        endcase
    end

    // Main FSM: next state and per-state datapath controls.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        illegal_pulse = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready_eff;
                pc_write   = ready_eff;
                if (ready_eff) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b01;
                illegal_pulse = decode_illegal;
                state_d       = decode_next;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ready_eff) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready_eff) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                pc_write  = branch_taken;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register; reset parks the machine in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced low while reset is held so no write can leak out.
    always_comb begin
        bus.PCWrite    = reset ? 1'b0 : pc_write;
        bus.AdrSrc     = reset ? 1'b0 : adr_src;
        bus.MemWrite   = reset ? 1'b0 : mem_write;
        bus.IRWrite    = reset ? 1'b0 : ir_write;
        bus.ResultSrc  = reset ? 2'b00 : result_src;
        bus.ALUSrcA    = reset ? 2'b00 : alu_src_a;
        bus.ALUSrcB    = reset ? 2'b00 : alu_src_b;
        bus.ALUControl = reset ? '0 : alu_ctrl;
        bus.ImmSrc     = reset ? 3'b000 : imm_src_of(bus.op);
        bus.RegWrite   = reset ? 1'b0 : reg_write;
        bus.illegal    = reset ? 1'b0 : illegal_pulse;
    end

endmodule

// File: tb/tb_control_multicycle.sv
// Directed bench for control_multicycle: a full-set instance (4-bit ALU
// control) walks every instruction class; a legacy 3-bit instance checks
// the reduced ALU set.
module tb_control_multicycle;
    import control_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset3;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;

    int total = 0;
    int bad   = 0;

    logic [3:0]  exp_r [16];
    logic [15:0] exp_ill;

    always #5 clk = ~clk;

    control_multicycle_if #(.ALUCTRL_W(4)) bus4 ();
    control_multicycle_if #(.ALUCTRL_W(3)) bus3 ();

    assign bus4.op = op;        assign bus3.op = op;
    assign bus4.funct3 = funct3;    assign bus3.funct3 = funct3;
    assign bus4.funct7b5 = funct7b5;  assign bus3.funct7b5 = funct7b5;
    assign bus4.Zero = zero;      assign bus3.Zero = zero;
    assign bus4.Lt = lt;        assign bus3.Lt = lt;
    assign bus4.Ltu = ltu;       assign bus3.Ltu = ltu;
    assign bus4.mem_ready = mem_ready; assign bus3.mem_ready = mem_ready;

    control_multicycle #(
        .ALUCTRL_W (4), .EXT_BRANCH (1'b1), .MEM_WAIT (1'b1)
    ) u_dut (
        .clk (clk), .reset (reset), .bus (bus4)
    );

    control_multicycle #(
        .ALUCTRL_W (3), .EXT_BRANCH (1'b1), .MEM_WAIT (1'b1)
    ) u_dut3 (
        .clk (clk), .reset (reset3), .bus (bus3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One ALU-class instruction starting from FETCH with mem_ready=1.
    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic ill, input logic [3:0] ctrl,
                           input logic [1:0] srcb);
        op = o; funct3 = f3; funct7b5 = f7;
        tick(); #1;
        chk({tag, "_illegal"}, {7'd0, bus4.illegal}, {7'd0, ill});
        if (!ill) begin
            tick(); #1;
            chk({tag, "_aluctrl"}, {4'd0, bus4.ALUControl}, {4'd0, ctrl});
            chk({tag, "_srcb"}, {6'd0, bus4.ALUSrcB}, {6'd0, srcb});
            tick(); #1;
            chk({tag, "_regwrite"}, {7'd0, bus4.RegWrite}, 8'd1);
        end else begin
            chk({tag, "_ill_regwrite"}, {7'd0, bus4.RegWrite}, 8'd0);
        end
        tick(); #1;
        chk({tag, "_fetch"}, {7'd0, bus4.IRWrite}, 8'd1);
    endtask

    initial begin
        exp_r   = '{4'h0, 4'h6, 4'h5, 4'h9, 4'h4, 4'h7, 4'h3, 4'h2,
                    4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
        exp_ill = 16'hDE00;
        reset = 1'b1; reset3 = 1'b1; op = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;

        // Reset held two cycles: all write enables low.
        tick(); tick(); #1;
        chk("rst_pcwrite", {7'd0, bus4.PCWrite}, 8'd0);
        chk("rst_irwrite", {7'd0, bus4.IRWrite}, 8'd0);
        chk("rst_memwrite", {7'd0, bus4.MemWrite}, 8'd0);
        chk("rst_regwrite", {7'd0, bus4.RegWrite}, 8'd0);
        chk("rst_illegal", {7'd0, bus4.illegal}, 8'd0);

        // Release: FETCH with mem_ready=1, then lw.
        op = OP_LOAD; reset = 1'b0; #1;
        chk("fetch_irwrite", {7'd0, bus4.IRWrite}, 8'd1);
        chk("fetch_pcwrite", {7'd0, bus4.PCWrite}, 8'd1);
        chk("fetch_srcb", {6'd0, bus4.ALUSrcB}, 8'd2);
        chk("fetch_resultsrc", {6'd0, bus4.ResultSrc}, 8'd2);
        tick(); #1;
        chk("dec_srca", {6'd0, bus4.ALUSrcA}, 8'd1);
        chk("dec_srcb", {6'd0, bus4.ALUSrcB}, 8'd1);
        chk("dec_irwrite", {7'd0, bus4.IRWrite}, 8'd0);
        chk("dec_illegal", {7'd0, bus4.illegal}, 8'd0);
        tick(); #1;
        chk("memadr_srca", {6'd0, bus4.ALUSrcA}, 8'd2);
        chk("memadr_aluctrl", {4'd0, bus4.ALUControl}, 8'd0);
        tick(); mem_ready = 1'b0; #1;
        chk("lw_read_adr", {7'd0, bus4.AdrSrc}, 8'd1);
        chk("lw_read_regwrite", {7'd0, bus4.RegWrite}, 8'd0);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("lw_hold_adr", {7'd0, bus4.AdrSrc}, 8'd1);
            chk("lw_hold_regwrite", {7'd0, bus4.RegWrite}, 8'd0);
            chk("lw_hold_irwrite", {7'd0, bus4.IRWrite}, 8'd0);
        end
        tick(); mem_ready = 1'b1; #1;
        chk("lw_last_read_adr", {7'd0, bus4.AdrSrc}, 8'd1);
        tick(); #1;
        chk("lw_wb_regwrite", {7'd0, bus4.RegWrite}, 8'd1);
        chk("lw_wb_resultsrc", {6'd0, bus4.ResultSrc}, 8'd1);

        // sw with single-cycle memory.
        op = OP_STORE;
        tick(); #1;
        chk("sw_fetch_irwrite", {7'd0, bus4.IRWrite}, 8'd1);
        tick(); #1;
        chk("sw_dec_immsrc", {5'd0, bus4.ImmSrc}, 8'd1);
        tick(); #1;
        chk("sw_memadr_memwrite", {7'd0, bus4.MemWrite}, 8'd0);
        tick(); #1;
        chk("sw_memwrite", {7'd0, bus4.MemWrite}, 8'd1);
        chk("sw_adrsrc", {7'd0, bus4.AdrSrc}, 8'd1);
        chk("sw_immsrc", {5'd0, bus4.ImmSrc}, 8'd1);
        tick(); #1;
        chk("sw_after_memwrite", {7'd0, bus4.MemWrite}, 8'd0);
        chk("sw_after_irwrite", {7'd0, bus4.IRWrite}, 8'd1);

        // sw stalled, then reset mid-MEMWRITE.
        tick(); tick(); tick(); mem_ready = 1'b0; #1;
        chk("sw2_memwrite", {7'd0, bus4.MemWrite}, 8'd1);
        tick(); #1;
        chk("sw2_memwrite_held", {7'd0, bus4.MemWrite}, 8'd1);
        reset = 1'b1; #1;
        chk("sw2_rst_memwrite", {7'd0, bus4.MemWrite}, 8'd0);
        chk("sw2_rst_adrsrc", {7'd0, bus4.AdrSrc}, 8'd0);
        tick(); reset = 1'b0; #1;
        chk("fetch_stall_irwrite", {7'd0, bus4.IRWrite}, 8'd0);
        chk("fetch_stall_pcwrite", {7'd0, bus4.PCWrite}, 8'd0);
        tick(); #1;
        chk("fetch_stall2_irwrite", {7'd0, bus4.IRWrite}, 8'd0);
        chk("fetch_stall2_srcb", {6'd0, bus4.ALUSrcB}, 8'd2);
        mem_ready = 1'b1; #1;
        chk("fetch_go_irwrite", {7'd0, bus4.IRWrite}, 8'd1);

        // R-type sweep over funct3 x funct7b5.
        for (int k = 0; k < 16; k++) begin
            run_alu($sformatf("r%0d", k), OP_RTYPE, k[2:0], k[3], exp_ill[k], exp_r[k], 2'b00);
        end

        // I-type spot checks.
        run_alu("srai", OP_ITYPE, 3'b101, 1'b1, 1'b0, ALU_SRA, 2'b01);
        run_alu("addi_b5", OP_ITYPE, 3'b000, 1'b1, 1'b0, ALU_ADD, 2'b01);
        run_alu("slli_b5", OP_ITYPE, 3'b001, 1'b1, 1'b1, ALU_ADD, 2'b01);

        // beq with Zero 0/1.
        op = OP_BRANCH; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        tick(); #1;
        chk("beq_dec_immsrc", {5'd0, bus4.ImmSrc}, 8'd2);
        tick(); #1;
        chk("beq_nt_pcwrite", {7'd0, bus4.PCWrite}, 8'd0);
        chk("beq_aluctrl", {4'd0, bus4.ALUControl}, 8'd1);
        chk("beq_srca", {6'd0, bus4.ALUSrcA}, 8'd2);
        zero = 1'b1; #1;
        chk("beq_t_pcwrite", {7'd0, bus4.PCWrite}, 8'd1);
        tick(); #1;
        // bltu Ltu 1/0.
        funct3 = 3'b110; ltu = 1'b1;
        tick(); tick(); #1;
        chk("bltu_t_pcwrite", {7'd0, bus4.PCWrite}, 8'd1);
        ltu = 1'b0; #1;
        chk("bltu_nt_pcwrite", {7'd0, bus4.PCWrite}, 8'd0);
        tick(); #1;
        // bne with Zero=1 not taken.
        funct3 = 3'b001; zero = 1'b1;
        tick(); tick(); #1;
        chk("bne_nt_pcwrite", {7'd0, bus4.PCWrite}, 8'd0);
        tick(); #1;
        // funct3=010 illegal.
        funct3 = 3'b010;
        tick(); #1;
        chk("b010_illegal", {7'd0, bus4.illegal}, 8'd1);
        chk("b010_pcwrite", {7'd0, bus4.PCWrite}, 8'd0);
        tick(); #1;
        chk("b010_after_illegal", {7'd0, bus4.illegal}, 8'd0);
        chk("b010_after_irwrite", {7'd0, bus4.IRWrite}, 8'd1);

        // jal.
        op = OP_JAL;
        tick(); tick(); #1;
        chk("jal_pcwrite", {7'd0, bus4.PCWrite}, 8'd1);
        chk("jal_srca", {6'd0, bus4.ALUSrcA}, 8'd1);
        chk("jal_srcb", {6'd0, bus4.ALUSrcB}, 8'd2);
        chk("jal_immsrc", {5'd0, bus4.ImmSrc}, 8'd3);
        tick(); #1;
        chk("jal_wb_regwrite", {7'd0, bus4.RegWrite}, 8'd1);
        tick(); #1;

        // lui.
        op = OP_LUI;
        tick(); tick(); #1;
        chk("lui_immsrc", {5'd0, bus4.ImmSrc}, 8'd4);
        chk("lui_srca", {6'd0, bus4.ALUSrcA}, 8'd2);
        chk("lui_srcb", {6'd0, bus4.ALUSrcB}, 8'd1);
        tick(); #1;
        chk("lui_wb_regwrite", {7'd0, bus4.RegWrite}, 8'd1);
        tick(); #1;

        // Unknown opcode.
        op = 7'h00;
        tick(); #1;
        chk("op00_illegal", {7'd0, bus4.illegal}, 8'd1);
        chk("op00_memwrite", {7'd0, bus4.MemWrite}, 8'd0);
        chk("op00_regwrite", {7'd0, bus4.RegWrite}, 8'd0);
        chk("op00_pcwrite", {7'd0, bus4.PCWrite}, 8'd0);
        tick(); #1;
        chk("op00_back_fetch", {7'd0, bus4.IRWrite}, 8'd1);
        chk("op00_after_illegal", {7'd0, bus4.illegal}, 8'd0);

        // Legacy 3-bit ALU control instance.
        reset3 = 1'b0; op = OP_RTYPE; funct3 = 3'b001; funct7b5 = 1'b0; #1;
        chk("l3_fetch_irwrite", {7'd0, bus3.IRWrite}, 8'd1);
        tick(); #1;
        chk("l3_sll_illegal", {7'd0, bus3.illegal}, 8'd1);
        chk("l3_sll_regwrite", {7'd0, bus3.RegWrite}, 8'd0);
        tick(); #1;
        chk("l3_sll_after_regwrite", {7'd0, bus3.RegWrite}, 8'd0);
        funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); #1;
        chk("l3_sub_illegal", {7'd0, bus3.illegal}, 8'd0);
        tick(); #1;
        chk("l3_sub_aluctrl", {5'd0, bus3.ALUControl}, 8'd1);
        tick(); #1;
        chk("l3_sub_regwrite", {7'd0, bus3.RegWrite}, 8'd1);
        tick(); #1;
        funct3 = 3'b010; funct7b5 = 1'b0;
        tick(); tick(); #1;
        chk("l3_slt_aluctrl", {5'd0, bus3.ALUControl}, 8'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
